// File: rtl/rtr_next_hop_addr_track_pkg.sv
// Shared constants, per-VC state encoding and width helpers for the
// registered next-hop address tracker.
package rtr_next_hop_addr_track_pkg;

  localparam int CONNECTIVITY_LINE = 0;
  localparam int CONNECTIVITY_RING = 1;
  localparam int CONNECTIVITY_FULL = 2;

  localparam int ROUTING_TYPE_PHASED_DOR = 0;

  typedef enum logic {
    RTR_NHA_STATE_IDLE   = 1'b0,
    RTR_NHA_STATE_ACTIVE = 1'b1
  } nha_state_e;

  function automatic int clogb(input int value);
    int width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) width++;
    return width;
  endfunction

  function automatic int num_neighbors_per_dim(input int connectivity,
                                               input int num_routers_per_dim);
    return (connectivity == CONNECTIVITY_FULL) ? num_routers_per_dim - 1 : 2;
  endfunction

endpackage

// File: rtl/rtr_next_hop_addr_track_calc.sv
// Combinational next-hop address and ring dateline computation for one
// head flit's lookahead route port.
module rtr_next_hop_addr_calc
  import rtr_next_hop_addr_track_pkg::*;
#(
  parameter int num_routers_per_dim = 4,
  parameter int num_dimensions      = 2,
  parameter int connectivity        = CONNECTIVITY_LINE,
  parameter int port_idx_width      = 3,
  localparam int dim_addr_width     = clogb(num_routers_per_dim),
  localparam int router_addr_width  = num_dimensions * dim_addr_width
) (
  input  logic [router_addr_width-1:0] router_address,
  input  logic [router_addr_width-1:0] dest_addr,
  input  logic [port_idx_width-1:0]    route_port,
  output logic [router_addr_width-1:0] next_addr,
  output logic                         next_dateline
);

  localparam int num_neighbors = num_neighbors_per_dim(connectivity, num_routers_per_dim);
  localparam logic [dim_addr_width-1:0] dim_max = dim_addr_width'(num_routers_per_dim - 1);
  localparam bit ring = (connectivity == CONNECTIVITY_RING);

  // Without wrap the coordinate rolls over modulo 2^dim_addr_width.
  function automatic logic [dim_addr_width-1:0] c_incr(input logic [dim_addr_width-1:0] a,
                                                       input logic wrap);
    return (wrap && (a == dim_max)) ? '0 : a + dim_addr_width'(1);
  endfunction

  function automatic logic [dim_addr_width-1:0] c_decr(input logic [dim_addr_width-1:0] a,
                                                       input logic wrap);
    return (wrap && (a == '0)) ? dim_max : a - dim_addr_width'(1);
  endfunction

  logic [dim_addr_width-1:0] coord;

  // Ejection ports match no dimension, so they fall through to router_address.
  always_comb begin
    next_addr     = router_address;
    next_dateline = 1'b0;
    coord         = '0;
    for (int d = 0; d < num_dimensions; d++) begin
      coord = router_address[d*dim_addr_width +: dim_addr_width];
      if (connectivity == CONNECTIVITY_FULL) begin
        if ((int'(route_port) >= d * num_neighbors) &&
            (int'(route_port) < (d + 1) * num_neighbors))
          next_addr[d*dim_addr_width +: dim_addr_width] =
            dest_addr[d*dim_addr_width +: dim_addr_width];
      end else if (int'(route_port) == 2 * d) begin
        next_addr[d*dim_addr_width +: dim_addr_width] = c_decr(coord, ring);
        if (ring && (coord == '0)) next_dateline = 1'b1;
      end else if (int'(route_port) == 2 * d + 1) begin
        next_addr[d*dim_addr_width +: dim_addr_width] = c_incr(coord, ring);
        if (ring && (coord == dim_max)) next_dateline = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtr_next_hop_addr_track.sv
// Per-VC registered next-hop address tracker: computes on head flits and
// holds the result for the VC until its next head.
//   state  | meaning
//   IDLE   | no packet in flight on this VC; only a head flit is legal
//   ACTIVE | head seen without tail; body/tail flits expected
module rtr_next_hop_addr_track
  import rtr_next_hop_addr_track_pkg::*;
#(
  parameter int num_vcs              = 4,
  parameter int num_resource_classes = 2,
  parameter int num_routers_per_dim  = 4,
  parameter int num_dimensions       = 2,
  parameter int num_nodes_per_router = 1,
  parameter int connectivity         = CONNECTIVITY_LINE,
  parameter int routing_type         = ROUTING_TYPE_PHASED_DOR,
  localparam int dim_addr_width      = clogb(num_routers_per_dim),
  localparam int router_addr_width   = num_dimensions * dim_addr_width,
  localparam int num_ports           = num_dimensions *
                                       num_neighbors_per_dim(connectivity, num_routers_per_dim) +
                                       num_nodes_per_router,
  localparam int port_idx_width      = clogb(num_ports),
  localparam int rcsel_width         = clogb(num_resource_classes),
  localparam int lar_info_width      = port_idx_width + rcsel_width,
  localparam int dest_info_width     = num_resource_classes * router_addr_width +
                                       clogb(num_nodes_per_router)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [router_addr_width-1:0]         router_address,
  input  logic                                 flit_valid,
  input  logic                                 flit_head,
  input  logic                                 flit_tail,
  input  logic [num_vcs-1:0]                   flit_sel_ivc,
  input  logic [dest_info_width-1:0]           dest_info,
  input  logic [lar_info_width-1:0]            lar_info,
  output logic                                 next_addr_valid,
  output logic [router_addr_width-1:0]         next_addr,
  output logic                                 next_dateline,
  output logic [num_vcs*router_addr_width-1:0] vc_next_addr,
  output logic [num_vcs-1:0]                   vc_active,
  output logic [num_vcs-1:0]                   error
);

  logic [port_idx_width-1:0]    route_port;
  logic [router_addr_width-1:0] dest_addr;
  logic [router_addr_width-1:0] calc_addr;
  logic                         calc_dateline;
  logic [num_vcs-1:0]           sel_oh;
  logic [num_vcs-1:0]           latch_vc;
  logic [num_vcs-1:0]           err_set;
  logic                         head_accept;
  nha_state_e                   state_q [num_vcs];
  nha_state_e                   state_d [num_vcs];

  assign route_port = lar_info[lar_info_width-1 -: port_idx_width];

  if (num_resource_classes > 1) begin : g_rcsel
    logic [rcsel_width-1:0] route_rcsel;
    assign route_rcsel = lar_info[rcsel_width-1:0];
    assign dest_addr   = dest_info[int'(route_rcsel)*router_addr_width +: router_addr_width];
  end else begin : g_single_rc
    assign dest_addr = dest_info[router_addr_width-1:0];
  end

  rtr_next_hop_addr_calc #(
    .num_routers_per_dim (num_routers_per_dim),
    .num_dimensions      (num_dimensions),
    .connectivity        (connectivity),
    .port_idx_width      (port_idx_width)
  ) u_calc (
    .router_address (router_address),
    .dest_addr      (dest_addr),
    .route_port     (route_port),
    .next_addr      (calc_addr),
    .next_dateline  (calc_dateline)
  );

  // Isolate the lowest set bit so a malformed multi-hot select still picks one VC.
  assign sel_oh      = flit_valid ? (flit_sel_ivc & (~flit_sel_ivc + num_vcs'(1))) : '0;
  assign head_accept = flit_head && (|sel_oh);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < num_vcs; i++) state_q[i] <= RTR_NHA_STATE_IDLE;
    end else begin
      for (int i = 0; i < num_vcs; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    latch_vc = '0;
    err_set  = '0;
    for (int i = 0; i < num_vcs; i++) begin
      state_d[i] = state_q[i];
      if (sel_oh[i]) begin
        if (flit_head) begin
          latch_vc[i] = 1'b1;
          err_set[i]  = (state_q[i] == RTR_NHA_STATE_ACTIVE);
          state_d[i]  = flit_tail ? RTR_NHA_STATE_IDLE : RTR_NHA_STATE_ACTIVE;
        end else if (state_q[i] == RTR_NHA_STATE_IDLE) begin
          err_set[i] = 1'b1;
        end else if (flit_tail) begin
          state_d[i] = RTR_NHA_STATE_IDLE;
        end
      end
    end
  end

  always_comb begin
    vc_active = '0;
    for (int i = 0; i < num_vcs; i++) vc_active[i] = (state_q[i] == RTR_NHA_STATE_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr_valid <= 1'b0;
      next_addr       <= '0;
      next_dateline   <= 1'b0;
      vc_next_addr    <= '0;
      error           <= '0;
    end else begin
      next_addr_valid <= head_accept;
      if (head_accept) begin
        next_addr     <= calc_addr;
        next_dateline <= calc_dateline;
      end
      for (int i = 0; i < num_vcs; i++)
        if (latch_vc[i]) vc_next_addr[i*router_addr_width +: router_addr_width] <= calc_addr;
      error <= error | err_set;
    end
  end

  a_sel_onehot : assert property (@(posedge clk) disable iff (reset)
                                  flit_valid |-> $onehot(flit_sel_ivc));
  a_routing_type : assert property (@(posedge clk) routing_type == ROUTING_TYPE_PHASED_DOR);

endmodule

// File: tb/tb_rtr_next_hop_addr_track.sv
// Drives LINE, RING and FULL instances with one flit stream and compares
// every cycle against a coordinate-level model of the routing rules.
module tb_rtr_next_hop_addr_track;
  import rtr_next_hop_addr_track_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flit_valid = 1'b0, flit_head = 1'b0, flit_tail = 1'b0;
  logic [3:0]  flit_sel_ivc = '0;
  logic [7:0]  dest_info = '0;
  logic [3:0]  lar_info = '0;
  logic [3:0]  ra   [3];
  logic        nav  [3];
  logic [3:0]  na   [3];
  logic        dl   [3];
  logic [15:0] vcna [3];
  logic [3:0]  act  [3];
  logic [3:0]  err  [3];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_nav = 0;
  int m_na [3] = '{0, 0, 0};
  int m_dl [3] = '{0, 0, 0};
  int m_vc [3][4];
  bit m_act [4] = '{0, 0, 0, 0};
  bit m_err [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  rtr_next_hop_addr_track #(.connectivity(CONNECTIVITY_LINE)) u_line (
    .clk(clk), .reset(reset), .router_address(ra[0]), .flit_valid(flit_valid),
    .flit_head(flit_head), .flit_tail(flit_tail), .flit_sel_ivc(flit_sel_ivc),
    .dest_info(dest_info), .lar_info(lar_info), .next_addr_valid(nav[0]),
    .next_addr(na[0]), .next_dateline(dl[0]), .vc_next_addr(vcna[0]),
    .vc_active(act[0]), .error(err[0]));

  rtr_next_hop_addr_track #(.connectivity(CONNECTIVITY_RING)) u_ring (
    .clk(clk), .reset(reset), .router_address(ra[1]), .flit_valid(flit_valid),
    .flit_head(flit_head), .flit_tail(flit_tail), .flit_sel_ivc(flit_sel_ivc),
    .dest_info(dest_info), .lar_info(lar_info), .next_addr_valid(nav[1]),
    .next_addr(na[1]), .next_dateline(dl[1]), .vc_next_addr(vcna[1]),
    .vc_active(act[1]), .error(err[1]));

  rtr_next_hop_addr_track #(.connectivity(CONNECTIVITY_FULL)) u_full (
    .clk(clk), .reset(reset), .router_address(ra[2]), .flit_valid(flit_valid),
    .flit_head(flit_head), .flit_tail(flit_tail), .flit_sel_ivc(flit_sel_ivc),
    .dest_info(dest_info), .lar_info(lar_info), .next_addr_valid(nav[2]),
    .next_addr(na[2]), .next_dateline(dl[2]), .vc_next_addr(vcna[2]),
    .vc_active(act[2]), .error(err[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // conn: 0 line, 1 ring, 2 full; addresses are two 2-bit coordinates, dim0 in the low bits.
  function automatic void hop(input int conn, input int raddr, input int port, input int rc,
                              input int dinfo, output int naddr, output int dline);
    int c [2];
    int dst, dim;
    dst   = (dinfo >> (4 * rc)) & 15;
    c[0]  = raddr & 3;
    c[1]  = (raddr >> 2) & 3;
    dline = 0;
    if (conn == 2) begin
      dim = port / 3;
      if (dim < 2) c[dim] = (dst >> (2 * dim)) & 3;
    end else begin
      dim = port / 2;
      if (dim < 2) begin
        if (port % 2 == 1) begin
          if (conn == 1 && c[dim] == 3) dline = 1;
          c[dim] = (c[dim] + 1) % 4;
        end else begin
          if (conn == 1 && c[dim] == 0) dline = 1;
          c[dim] = (c[dim] + 3) % 4;
        end
      end
    end
    naddr = c[0] + 4 * c[1];
  endfunction

  always @(posedge clk) begin
    int v;
    if (reset) begin
      m_nav = 0;
      for (int k = 0; k < 3; k++) begin
        m_na[k] = 0;
        m_dl[k] = 0;
        for (int i = 0; i < 4; i++) m_vc[k][i] = 0;
      end
      for (int i = 0; i < 4; i++) begin
        m_act[i] = 0;
        m_err[i] = 0;
      end
    end else begin
      m_nav = 0;
      v = -1;
      if (flit_valid)
        for (int i = 3; i >= 0; i--) if (flit_sel_ivc[i]) v = i;
      if (v >= 0) begin
        if (flit_head) begin
          m_nav = 1;
          for (int k = 0; k < 3; k++) begin
            hop(k, int'(ra[k]), int'(lar_info[3:1]), int'(lar_info[0]), int'(dest_info),
                m_na[k], m_dl[k]);
            m_vc[k][v] = m_na[k];
          end
          if (m_act[v]) m_err[v] = 1;
          m_act[v] = !flit_tail;
        end else if (!m_act[v]) begin
          m_err[v] = 1;
        end else if (flit_tail) begin
          m_act[v] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0]  e_act, e_err;
    logic [15:0] e_vc;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        e_act[i] = m_act[i];
        e_err[i] = m_err[i];
      end
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 4; i++) e_vc[4*i +: 4] = 4'(m_vc[k][i]);
        check($sformatf("valid[%0d]", k), 32'(nav[k]), 32'(m_nav));
        check($sformatf("next_addr[%0d]", k), 32'(na[k]), 32'(m_na[k]));
        check($sformatf("dateline[%0d]", k), 32'(dl[k]), 32'(m_dl[k]));
        check($sformatf("vc_next_addr[%0d]", k), 32'(vcna[k]), 32'(e_vc));
        check($sformatf("vc_active[%0d]", k), 32'(act[k]), 32'(e_act));
        check($sformatf("error[%0d]", k), 32'(err[k]), 32'(e_err));
      end
    end
  end

  task automatic drive(input bit v, input bit h, input bit t, input int vc, input int port,
                       input int rc, input logic [7:0] di);
    flit_valid   = v;
    flit_head    = h;
    flit_tail    = t;
    flit_sel_ivc = v ? 4'(1 << vc) : 4'b0;
    lar_info     = 4'(port * 2 + rc);
    dest_info    = di;
    @(posedge clk);
    @(negedge clk);
    flit_valid   = 1'b0;
    flit_head    = 1'b0;
    flit_tail    = 1'b0;
    flit_sel_ivc = '0;
  endtask

  initial begin
    ra[0] = 4'h9;  // LINE router (1,2)
    ra[1] = 4'h3;  // RING router (3,0)
    ra[2] = 4'h0;  // FULL router (0,0)
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("lit_reset_valid", 32'(nav[0]), 32'd0);
    check("lit_reset_active", 32'(act[1]), 32'd0);
    reset = 1'b0;

    drive(1, 1, 1, 0, 1, 0, 8'hE5);
    check("lit_line_addr", 32'(na[0]), 32'hA);
    check("lit_line_valid", 32'(nav[0]), 32'd1);
    check("lit_line_dateline", 32'(dl[0]), 32'd0);
    check("lit_line_active", 32'(act[0]), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    check("lit_valid_pulse", 32'(nav[0]), 32'd0);

    drive(1, 1, 0, 2, 1, 0, 8'hE5);
    check("lit_ring_up_addr", 32'(na[1]), 32'h0);
    check("lit_ring_up_dateline", 32'(dl[1]), 32'd1);
    check("lit_ring_active", 32'(act[1]), 32'h4);
    drive(1, 0, 1, 2, 0, 0, 8'h00);
    drive(1, 1, 1, 2, 2, 0, 8'hE5);
    check("lit_ring_down_addr", 32'(na[1]), 32'hF);
    check("lit_ring_down_dateline", 32'(dl[1]), 32'd1);

    drive(1, 1, 1, 0, 4, 1, 8'hE5);
    check("lit_full_rc1", 32'(na[2]), 32'hC);
    drive(1, 1, 1, 0, 4, 0, 8'hE5);
    check("lit_full_rc0", 32'(na[2]), 32'h4);

    drive(1, 1, 0, 1, 0, 0, 8'h00);
    drive(1, 1, 0, 3, 3, 1, 8'h00);
    for (int b = 0; b < 3; b++) begin
      drive(1, 0, 0, 1, 5, 1, 8'hFF);
      drive(1, 0, 0, 3, 2, 0, 8'h11);
    end
    drive(1, 0, 1, 1, 0, 0, 8'h00);
    check("lit_vc1_tail_only", 32'(act[0]), 32'h8);
    drive(1, 0, 1, 3, 0, 0, 8'h00);
    check("lit_vc3_tail", 32'(act[0]), 32'h0);
    check("lit_vc1_addr", 32'(vcna[0][7:4]), 32'h8);
    check("lit_vc3_addr", 32'(vcna[0][15:12]), 32'hD);

    drive(1, 1, 0, 0, 1, 0, 8'h00);
    drive(1, 1, 0, 0, 3, 0, 8'h00);
    check("lit_head_on_active_err", 32'(err[0]), 32'h1);
    check("lit_head_on_active_addr", 32'(vcna[0][3:0]), 32'hD);
    check("lit_head_on_active_state", 32'(act[0]), 32'h1);
    drive(1, 0, 1, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 1, 0, 0, 8'h00);
    check("lit_body_on_idle_err", 32'(err[0]), 32'h3);
    check("lit_body_on_idle_state", 32'(act[0]), 32'h0);

    drive(1, 1, 0, 2, 1, 0, 8'h00);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    check("lit_reset_mid_active", 32'(act[0]), 32'h0);
    check("lit_reset_mid_error", 32'(err[0]), 32'h0);
    check("lit_reset_mid_vcaddr", 32'(vcna[0]), 32'h0);
    check("lit_reset_mid_addr", 32'(na[0]), 32'h0);
    reset = 1'b0;
    drive(1, 0, 0, 2, 0, 0, 8'h00);
    check("lit_body_after_reset", 32'(err[0]), 32'h4);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(149) == 0) begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) ra[k] = 4'($urandom);
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        reset = 1'b0;
      end else begin
        drive($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(1) == 1,
              int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(1)),
              8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
